fft_radix2_stream: RTL
======================

# fft_radix2_stream

Parametrised streaming radix-2 FFT core and successor to the fixed 16-point, 16-port parallel `FFT16_top`. It accepts complex samples one per handshake and computes an in-place iterative decimation-in-time (DIT) FFT with a single butterfly unit. It then streams the spectrum out in natural order under backpressure. It sits between a sample source (ADC/decimator) and spectral post-processing. It adds a runtime per-stage scaling mode.

## Interface
Parameters:
- `WORD_SIZE`, 16: signed two's-complement width of each re/im component.
- `FRACTION`, 8: fractional bits (Q format) of data and twiddles.
- `LOG2_POINTS`, 4: transform size N = 2^LOG2_POINTS; legal range 2..10.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: synchronous active-high reset.
- `i_scale` in 1: 1 = divide by 2 after every stage. Sampled with the first sample of each frame.
- `i_in_valid` in 1: input sample valid.
- `o_in_ready` out 1: core accepts a sample this cycle.
- `i_in_re`, `i_in_im` in WORD_SIZE: input sample.
- `o_out_valid` out 1: output bin valid.
- `i_out_ready` in 1: sink accepts the bin.
- `o_out_re`, `o_out_im` out WORD_SIZE: output bin X[k].
- `o_out_index` out LOG2_POINTS: bin index k.
- `o_out_last` out 1: high with bin N-1.
- `o_busy` out 1: high in COMPUTE or UNLOAD.
- `o_FFT_cycle_done` out 1: one-cycle pulse after the last bin is accepted.

## Operation
- Storage is an N-entry complex register array, frame-buffered. No overlap between frames.
- The FSM has three states: LOAD → COMPUTE → UNLOAD → LOAD.
- **LOAD**
  - `o_in_ready`=1.
  - On `i_in_valid & o_in_ready`, sample n (counter 0..N-1) is written to address bitrev(n).
  - Cycles without valid are ignored.
  - After sample N-1 is accepted, the FSM goes to COMPUTE and the counter clears.
- **COMPUTE**
  - Stages s = 0..LOG2_POINTS-1, each with butterflies j = 0..N/2-1, one butterfly per cycle.
  - Addressing: pos = j mod 2^s; a = (j>>s)·2^(s+1) + pos; b = a + 2^s.
  - Twiddle index: k = pos·(N>>(s+1)).
  - Butterfly: t = W_k·B, with W_k = cos(2πk/N) − j·sin(2πk/N).
  - Each partial product is rounded: (p + 2^(FRACTION-1)) >>> FRACTION, arithmetic shift.
  - Outputs: A' = A + t, B' = A − t, both written back in the same cycle.
  - Scale mode: A' and B' are shifted >>>1 (truncating) before writeback.
  - All sums wrap modulo 2^WORD_SIZE. There is no saturation.
  - The twiddle table has N/2 entries in Q(FRACTION), is rounded to nearest, and is generated at elaboration.
  - After the final butterfly of the last stage, the FSM goes to UNLOAD.
- **UNLOAD**
  - `o_out_valid`=1.
  - Outputs are presented combinationally from address `o_out_index`.
  - The index increments on `o_out_valid & i_out_ready`.
  - When bin N-1 is accepted: `o_FFT_cycle_done`=1 for the next cycle, the index clears, and the FSM goes to LOAD.
  - While the sink stalls, all out signals are held stable.
- **Reset** (any state, including mid-COMPUTE or mid-UNLOAD)
  - Next state LOAD; all counters 0; frame discarded. Array contents need not be cleared.
- **Reset values**
  - `o_out_valid`=0, `o_busy`=0, `o_FFT_cycle_done`=0, `o_out_last`=0, `o_out_index`=0.
  - `o_in_ready`=0 while `i_rst` is high, and 1 in the first cycle after `i_rst` is released.

## Timing
- With continuous input, sample 0 is accepted at cycle 0 and sample N-1 at cycle N-1.
- COMPUTE occupies cycles N .. N + LOG2_POINTS·N/2 − 1.
- The first `o_out_valid` occurs at cycle N + LOG2_POINTS·N/2. For N=16 this is cycle 48.
- With `i_out_ready` held high, bins stream 1 per cycle. The last bin is accepted at cycle 63 (N=16), and `o_FFT_cycle_done` is at cycle 64.
- `o_in_ready` rises in the same cycle as `o_FFT_cycle_done`.
- Input gaps and output stalls add cycles 1:1. There are no other latency variations.

## Test plan
All scenarios use defaults: WORD_SIZE=16, FRACTION=8, N=16.
- **Impulse:** x[0]=0x0100, rest 0, `i_scale`=0 → all 16 bins re=0x0100, im=0x0000. First `o_out_valid` 48 cycles after sample 0; `o_out_last` with index 15; `o_FFT_cycle_done` pulse exactly one cycle.
- **DC:** all x=0x0100+j0, `i_scale`=0 → X[0]=0x1000+j0, all other bins exactly 0. Repeat with `i_scale`=1 → X[0]=0x0100, others 0.
- **Nyquist:** x[n] alternating 0x0100 / 0xFF00, `i_scale`=0 → X[8].re=0x1000; all other bins within ±2 LSB of 0.
- **Handshake:**
  - Random `i_in_valid` gaps during LOAD → results identical to the impulse case.
  - `i_out_ready` low for 5 cycles at index 3 → re/im/index held stable; no bin skipped or duplicated.
- **Reset mid-operation:** assert `i_rst` for 1 cycle during COMPUTE stage 2 → next cycle `o_busy`=0, `o_in_ready`=1, `o_out_valid`=0. A following impulse frame yields correct output.
- **Back-to-back frames:** 3 frames (impulse, DC, Nyquist) with `i_scale` toggled between frames → each frame matches its expected result, and each frame uses the scale value sampled at its own first sample.

Source files
------------

// File: rtl/fft_radix2_stream.sv
// Streaming radix-2 DIT FFT, N = 2**LOG2_POINTS points, one butterfly per cycle.
// Frames are loaded in bit-reversed order, transformed in place, then
// unloaded in natural order under sink backpressure.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_scale               per-stage /2 enable, captured with sample 0 of a frame
//   i_in_valid/o_in_ready input handshake, i_in_re/i_in_im complex sample
//   o_out_valid/i_out_ready output handshake, o_out_re/o_out_im bin X[k]
//   o_out_index           bin index k, o_out_last marks bin N-1
//   o_busy                high while computing or unloading
//   o_FFT_cycle_done      one-cycle pulse after the last bin is accepted
module fft_radix2_stream #(
  parameter int WORD_SIZE   = 16,
  parameter int FRACTION    = 8,
  parameter int LOG2_POINTS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_scale,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [WORD_SIZE-1:0]   i_in_re,
  input  logic [WORD_SIZE-1:0]   i_in_im,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [WORD_SIZE-1:0]   o_out_re,
  output logic [WORD_SIZE-1:0]   o_out_im,
  output logic [LOG2_POINTS-1:0] o_out_index,
  output logic                   o_out_last,
  output logic                   o_busy,
  output logic                   o_FFT_cycle_done
);

  localparam int N    = 1 << LOG2_POINTS;
  localparam int HALF = N / 2;
  localparam int LW   = LOG2_POINTS;
  localparam int KW   = LOG2_POINTS - 1;
  localparam int SW   = $clog2(LOG2_POINTS);
  localparam int PW   = 2 * WORD_SIZE;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_POINTS - 1);
  localparam logic [LW-1:0] LAST_IDX   = LW'(N - 1);
  localparam real PI  = 3.14159265358979323846;
  localparam real ONE = 2.0 ** FRACTION;

  typedef logic signed [WORD_SIZE-1:0] word_t;
  typedef logic signed [PW-1:0]        prod_t;
  typedef enum logic [1:0] {S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_UNLOAD = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  word_t         r_re [N];
  word_t         r_im [N];
  logic [LW-1:0] r_cnt;    // load sample counter, then unload bin index
  logic [KW-1:0] r_bfly;
  logic [SW-1:0] r_stage;
  logic          r_scale;
  logic          r_done;

  word_t         w_tw_re [HALF];
  word_t         w_tw_im [HALF];
  logic [LW-1:0] w_a, w_b;
  logic [KW-1:0] w_k;
  word_t         w_ar, w_ai, w_br, w_bi, w_tr, w_ti;
  word_t         w_na_re, w_na_im, w_nb_re, w_nb_im;

  // W_k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded to nearest in Q(FRACTION)
  for (genvar k = 0; k < HALF; k++) begin : g_twiddle
    localparam real ANG = 2.0 * PI * real'(k) / real'(N);
    assign w_tw_re[k] = word_t'($rtoi($floor($cos(ANG) * ONE + 0.5)));
    assign w_tw_im[k] = word_t'($rtoi($floor(-$sin(ANG) * ONE + 0.5)));
  end

  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] v);
    for (int unsigned i = 0; i < LW; i++) bitrev[i] = v[LW-1-i];
  endfunction

  // Rounded Q(FRACTION) product, wrapped to the data width
  function automatic word_t rmul(input word_t x, input word_t y);
    prod_t p;
    p = prod_t'(x) * prod_t'(y) + prod_t'(1 <<< (FRACTION - 1));
    return word_t'(p >>> FRACTION);
  endfunction

  always_comb begin
    int unsigned v_j, v_s, v_pos, v_a;
    v_j   = 32'(r_bfly);
    v_s   = 32'(r_stage);
    v_pos = v_j & ((32'd1 << v_s) - 32'd1);
    v_a   = ((v_j >> v_s) << (v_s + 32'd1)) | v_pos;
    w_a   = LW'(v_a);
    w_b   = LW'(v_a | (32'd1 << v_s));
    w_k   = KW'(v_pos << (32'(LOG2_POINTS) - 32'd1 - v_s));

    w_ar = r_re[w_a];
    w_ai = r_im[w_a];
    w_br = r_re[w_b];
    w_bi = r_im[w_b];
    w_tr = rmul(w_tw_re[w_k], w_br) - rmul(w_tw_im[w_k], w_bi);
    w_ti = rmul(w_tw_re[w_k], w_bi) + rmul(w_tw_im[w_k], w_br);

    // sums wrap at the data width first, scaling shifts the wrapped result
    w_na_re = w_ar + w_tr;
    w_na_im = w_ai + w_ti;
    w_nb_re = w_ar - w_tr;
    w_nb_im = w_ai - w_ti;
    if (r_scale) begin
      w_na_re = w_na_re >>> 1;
      w_na_im = w_na_im >>> 1;
      w_nb_re = w_nb_re >>> 1;
      w_nb_im = w_nb_im >>> 1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (i_in_valid && r_cnt == LAST_IDX) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (r_stage == LAST_STAGE && &r_bfly) w_state_nxt = S_UNLOAD;
      S_UNLOAD:  if (i_out_ready && r_cnt == LAST_IDX) w_state_nxt = S_LOAD;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_bfly  <= '0;
      r_stage <= '0;
      r_scale <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_LOAD: if (i_in_valid) begin
          if (r_cnt == '0) r_scale <= i_scale;
          r_cnt <= r_cnt + 1'b1;
        end
        S_COMPUTE: begin
          r_bfly <= r_bfly + 1'b1;
          if (&r_bfly) r_stage <= (r_stage == LAST_STAGE) ? '0 : r_stage + 1'b1;
        end
        S_UNLOAD: if (i_out_ready) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // sample storage carries no reset; a discarded frame is simply overwritten
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_LOAD && i_in_valid) begin
        r_re[bitrev(r_cnt)] <= i_in_re;
        r_im[bitrev(r_cnt)] <= i_in_im;
      end else if (r_state == S_COMPUTE) begin
        r_re[w_a] <= w_na_re;
        r_im[w_a] <= w_na_im;
        r_re[w_b] <= w_nb_re;
        r_im[w_b] <= w_nb_im;
      end
    end
  end

  assign o_in_ready       = (r_state == S_LOAD) && !i_rst;
  assign o_out_valid      = (r_state == S_UNLOAD);
  assign o_busy           = (r_state != S_LOAD);
  assign o_out_index      = (r_state == S_UNLOAD) ? r_cnt : '0;
  assign o_out_last       = (r_state == S_UNLOAD) && (r_cnt == LAST_IDX);
  assign o_out_re         = r_re[r_cnt];
  assign o_out_im         = r_im[r_cnt];
  assign o_FFT_cycle_done = r_done;

endmodule
